// File: rtl/barrier_pkg.sv
// ----------------------------------------------------------------------------
// barrier_pkg
// Shared types and constants for the barrier scan controller slice.
//   COORD_W          : width of every barrier coordinate / half-extent
//   COLL_*           : one-hot tank collision side codes from the checker
//   barrier_entry_t  : one barrier table entry {en, x, y, h, l}
//   scan_state_t     : scan sequencer states
// ----------------------------------------------------------------------------
package barrier_pkg;

  localparam int COORD_W = 10;

  localparam logic [3:0] COLL_NONE   = 4'b0000;
  localparam logic [3:0] COLL_LEFT   = 4'b0001;
  localparam logic [3:0] COLL_RIGHT  = 4'b0010;
  localparam logic [3:0] COLL_TOP    = 4'b0100;
  localparam logic [3:0] COLL_BOTTOM = 4'b1000;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] l;
  } barrier_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_t;

  // Disabled entry with zero geometry; the table's reset content.
  function automatic barrier_entry_t entry_null();
    barrier_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/barrier_table.sv
// ----------------------------------------------------------------------------
// barrier_table
// NUM_BARRIERS-entry register file of barrier descriptors.
//   Clk, Reset  : clock, asynchronous active-low reset (clears every entry)
//   we, waddr   : write strobe and entry index; out-of-range indices dropped
//   wdata       : entry written at the clock edge
//   raddr       : combinational read index
//   rdata       : entry at raddr
// ----------------------------------------------------------------------------
module barrier_table
  import barrier_pkg::*;
#(
  parameter int NUM_BARRIERS = 8,
  parameter int IDX_W        = $clog2(NUM_BARRIERS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  barrier_entry_t       wdata,
  input  logic [IDX_W-1:0]     raddr,
  output barrier_entry_t       rdata
);

  localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_BARRIERS);

  barrier_entry_t table_r [NUM_BARRIERS];
  logic           addr_ok_s;

  // Only indices that name a real entry may be written (matters when
  // NUM_BARRIERS is not a power of two).
  assign addr_ok_s = ({1'b0, waddr} < NUM_EXT);

  // Entry storage: cleared on reset, single write port
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        table_r[i] <= entry_null();
      end
    end else if (we && addr_ok_s) begin
      table_r[waddr] <= wdata;
    end
  end

  assign rdata = table_r[raddr];

endmodule

// File: rtl/barrier_scan_ctrl.sv
// ----------------------------------------------------------------------------
// barrier_scan_ctrl
// Time-shares one barrier collision checker over the barrier table once per
// frame and publishes OR-accumulated per-frame collision results.
//   Clk, Reset                 : clock, asynchronous active-low reset
//   frame_start                : pulse, begin a scan (IDLE only)
//   cfg_we/addr/en/x/y/h/l     : table write port, accepted while cfg_ready
//   cfg_ready                  : high in IDLE
//   BarrierX/Y, Barrier_*      : registered geometry presented to the checker
//   chk_p1/p2, chk_b1/b2       : checker outputs for the presented geometry
//   player_*/bullet_* outputs  : per-frame results, updated on frame_done
//   frame_done                 : one-cycle pulse when results update
//   overrun                    : sticky, frame_start seen while busy
// ----------------------------------------------------------------------------
module barrier_scan_ctrl
  import barrier_pkg::*;
#(
  parameter int NUM_BARRIERS = 8,
  parameter int CHECK_LAT    = 1,
  parameter int IDX_W        = $clog2(NUM_BARRIERS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic                 cfg_en,
  input  logic [COORD_W-1:0]   cfg_x,
  input  logic [COORD_W-1:0]   cfg_y,
  input  logic [COORD_W-1:0]   cfg_h,
  input  logic [COORD_W-1:0]   cfg_l,
  output logic                 cfg_ready,
  output logic [COORD_W-1:0]   BarrierX,
  output logic [COORD_W-1:0]   BarrierY,
  output logic [COORD_W-1:0]   Barrier_Height_Halved,
  output logic [COORD_W-1:0]   Barrier_Length_Halved,
  input  logic [3:0]           chk_p1,
  input  logic [3:0]           chk_p2,
  input  logic                 chk_b1,
  input  logic                 chk_b2,
  output logic [3:0]           player_1_collision,
  output logic [3:0]           player_2_collision,
  output logic                 bullet_1_collision,
  output logic                 bullet_2_collision,
  output logic [IDX_W-1:0]     bullet_1_idx,
  output logic [IDX_W-1:0]     bullet_2_idx,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BARRIERS - 1);
  localparam logic [2:0]       WAIT_LAST = 3'(CHECK_LAT - 1);

  scan_state_t        state_r, state_s;
  logic [IDX_W-1:0]   idx_r;
  logic [2:0]         wait_cnt_r;

  barrier_entry_t     wr_entry_s, rd_entry_s;
  logic               tbl_we_s;
  logic               start_s;
  logic               sample_s;

  logic [COORD_W-1:0] geo_x_r, geo_y_r, geo_h_r, geo_l_r;
  logic [3:0]         p1_acc_r, p2_acc_r;
  logic               b1_acc_r, b2_acc_r;
  logic [IDX_W-1:0]   b1_idx_acc_r, b2_idx_acc_r;

  logic [3:0]         p1_res_r, p2_res_r;
  logic               b1_res_r, b2_res_r;
  logic [IDX_W-1:0]   b1_idx_res_r, b2_idx_res_r;
  logic               frame_done_r, overrun_r, cfg_ready_r;

  // Writes only land in IDLE, so the table is frozen for the whole scan.
  // A write coinciding with frame_start lands before the first LOAD reads it.
  assign tbl_we_s   = cfg_we && (state_r == ST_IDLE);
  assign wr_entry_s = '{en: cfg_en, x: cfg_x, y: cfg_y, h: cfg_h, l: cfg_l};
  assign start_s    = frame_start && (state_r == ST_IDLE);
  assign sample_s   = (state_r == ST_SAMPLE) && rd_entry_s.en;

  barrier_table #(
    .NUM_BARRIERS (NUM_BARRIERS),
    .IDX_W        (IDX_W)
  ) u_table (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (tbl_we_s),
    .waddr (cfg_addr),
    .wdata (wr_entry_s),
    .raddr (idx_r),
    .rdata (rd_entry_s)
  );

  // Next-state decode of the scan sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        if (idx_r == IDX_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, table index and checker latency counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      wait_cnt_r <= 3'd0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        idx_r <= '0;
      end else if (state_r == ST_SAMPLE && idx_r != IDX_LAST) begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (state_r == ST_LOAD) begin
        wait_cnt_r <= 3'd0;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 3'd1;
      end
    end
  end

  // Geometry presented to the checker; holds the last entry after a scan
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      geo_x_r <= '0;
      geo_y_r <= '0;
      geo_h_r <= '0;
      geo_l_r <= '0;
    end else if (state_r == ST_LOAD) begin
      geo_x_r <= rd_entry_s.x;
      geo_y_r <= rd_entry_s.y;
      geo_h_r <= rd_entry_s.h;
      geo_l_r <= rd_entry_s.l;
    end
  end

  // Per-scan accumulators; bullet index keeps the first (lowest) hit
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      p1_acc_r     <= COLL_NONE;
      p2_acc_r     <= COLL_NONE;
      b1_acc_r     <= 1'b0;
      b2_acc_r     <= 1'b0;
      b1_idx_acc_r <= '0;
      b2_idx_acc_r <= '0;
    end else if (start_s) begin
      p1_acc_r     <= COLL_NONE;
      p2_acc_r     <= COLL_NONE;
      b1_acc_r     <= 1'b0;
      b2_acc_r     <= 1'b0;
      b1_idx_acc_r <= '0;
      b2_idx_acc_r <= '0;
    end else if (sample_s) begin
      p1_acc_r <= p1_acc_r | chk_p1;
      p2_acc_r <= p2_acc_r | chk_p2;
      if (chk_b1 && !b1_acc_r) begin
        b1_acc_r     <= 1'b1;
        b1_idx_acc_r <= idx_r;
      end
      if (chk_b2 && !b2_acc_r) begin
        b2_acc_r     <= 1'b1;
        b2_idx_acc_r <= idx_r;
      end
    end
  end

  // Published results: only ever copied from a completed scan
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      p1_res_r     <= COLL_NONE;
      p2_res_r     <= COLL_NONE;
      b1_res_r     <= 1'b0;
      b2_res_r     <= 1'b0;
      b1_idx_res_r <= '0;
      b2_idx_res_r <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        p1_res_r     <= p1_acc_r;
        p2_res_r     <= p2_acc_r;
        b1_res_r     <= b1_acc_r;
        b2_res_r     <= b2_acc_r;
        b1_idx_res_r <= b1_idx_acc_r;
        b2_idx_res_r <= b2_idx_acc_r;
      end
    end
  end

  // Status flags: ready follows the upcoming state, overrun is sticky
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cfg_ready_r <= 1'b1;
      overrun_r   <= 1'b0;
    end else begin
      cfg_ready_r <= (state_s == ST_IDLE);
      if (frame_start && state_r != ST_IDLE) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign cfg_ready             = cfg_ready_r;
  assign BarrierX              = geo_x_r;
  assign BarrierY              = geo_y_r;
  assign Barrier_Height_Halved = geo_h_r;
  assign Barrier_Length_Halved = geo_l_r;
  assign player_1_collision    = p1_res_r;
  assign player_2_collision    = p2_res_r;
  assign bullet_1_collision    = b1_res_r;
  assign bullet_2_collision    = b2_res_r;
  assign bullet_1_idx          = b1_idx_res_r;
  assign bullet_2_idx          = b2_idx_res_r;
  assign frame_done            = frame_done_r;
  assign overrun               = overrun_r;

endmodule
